// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: bus request/grant/response FSM with byte lanes.
// Ports: clk_i/rst_n_i, M-stage access in, bus_* channel, stall/wb/misalign out. Macro: LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             mem_wr_en_m_i,
  input  logic             result_src_m_i,
  input  logic             mem_byte_en_m_i,
  input  logic [WIDTH-1:0] alu_result_m_i,
  input  logic [WIDTH-1:0] rd_data2_m_i,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [WIDTH-1:0] bus_addr_o,
  output logic [WIDTH-1:0] bus_wdata_o,
  output logic [3:0]       bus_be_o,
  input  logic             bus_gnt_i,
  input  logic             bus_rvalid_i,
  input  logic [WIDTH-1:0] bus_rdata_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic             wb_valid_o,
  output logic             misalign_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [3:0]       r_be;
  logic             r_byte;
  logic [1:0]       r_lane;
  logic             r_load;
  logic [WIDTH-1:0] r_wb_data;

  logic             w_access;
  logic             w_misal;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_addr;
  logic [7:0]       w_rbyte;
  logic [WIDTH-1:0] w_fmt;

  assign w_access = mem_wr_en_m_i | result_src_m_i;

  assign w_be    = mem_byte_en_m_i ? (4'b0001 << alu_result_m_i[1:0])
                                   : 4'hF;
  assign w_wdata = mem_byte_en_m_i ? {4{rd_data2_m_i[7:0]}}
                                   : rd_data2_m_i;
  assign w_addr  = {alu_result_m_i[WIDTH-1:2], 2'b00};

  // Byte loads pick the lane latched at request time and sign-extend.
  assign w_rbyte = bus_rdata_i[{r_lane, 3'b000} +: 8];
  assign w_fmt   = r_byte ? {{(WIDTH-8){w_rbyte[7]}}, w_rbyte}
                          : bus_rdata_i;

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis;

  assign w_misal    = ~mem_byte_en_m_i & (alu_result_m_i[1:0] != 2'b00);
  assign misalign_o = (r_state == DONE) & r_mis;
  assign wb_valid_o = (r_state == DONE) & r_load & ~r_mis;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mis <= 1'b0;
    end else if (r_state == IDLE && w_access) begin
      r_mis <= w_misal;
    end
  end
`else
  assign w_misal    = 1'b0;
  assign misalign_o = 1'b0;
  assign wb_valid_o = (r_state == DONE) & r_load;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_access) begin
          w_next = w_misal ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          w_next = r_we ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
    endcase
  end

  // Reset gating keeps stall low while rst_n_i is held with an access present.
  assign stall_o = (rst_n_i & (r_state == IDLE) & w_access)
                 | (r_state == REQ)
                 | (r_state == WAIT);

  assign bus_req_o   = (r_state == REQ);
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;
  assign bus_be_o    = r_be;
  assign wb_data_o   = r_wb_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= 4'h0;
      r_byte    <= 1'b0;
      r_lane    <= 2'b00;
      r_load    <= 1'b0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_access) begin
        r_load <= ~mem_wr_en_m_i;
      end
      if (r_state == IDLE && w_next == REQ) begin
        r_we    <= mem_wr_en_m_i;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_byte  <= mem_byte_en_m_i;
        r_lane  <= alu_result_m_i[1:0];
      end
      if (r_state == WAIT && bus_rvalid_i) begin
        r_wb_data <= w_fmt;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed transactions, cycle model.
// Compares stall/req/wb/misalign/bus fields every cycle plus literal pins.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rsrc, byte_en;
  logic [31:0] alu, rd2;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall, wb_valid, misalign;
  logic [31:0] wb_data;

  mem_stage_lsu #(.WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .mem_wr_en_m_i  (wr_en),
    .result_src_m_i (rsrc),
    .mem_byte_en_m_i(byte_en),
    .alu_result_m_i (alu),
    .rd_data2_m_i   (rd2),
    .bus_req_o      (bus_req),
    .bus_we_o       (bus_we),
    .bus_addr_o     (bus_addr),
    .bus_wdata_o    (bus_wdata),
    .bus_be_o       (bus_be),
    .bus_gnt_i      (gnt),
    .bus_rvalid_i   (rvalid),
    .bus_rdata_i    (rdata),
    .stall_o        (stall),
    .wb_data_o      (wb_data),
    .wb_valid_o     (wb_valid),
    .misalign_o     (misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_wbv, exp_mis, exp_fchk, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_wb;
  logic [3:0]  exp_be;

  int          tot_stall = 0, tot_req = 0, tot_wbv = 0, tot_mis = 0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata, last_wb;
  logic [3:0]  cap_be;
  int          d_stall, d_req, d_wbv, d_mis;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] m_be(input bit b, input logic [31:0] a);
    int lane;
    lane = int'(a % 4);
    return b ? 4'(1 << lane) : 4'hF;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input bit b, input logic [31:0] d);
    return b ? (d % 256) * 32'h0101_0101 : d;
  endfunction

  function automatic logic [31:0] m_load(input bit b, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    v = (rd >> (8 * (a % 4))) % 256;
    if (v >= 128) v = v - 256;
    return b ? v : rd;
  endfunction

  function automatic bit m_trap(input bit b, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return !b && (a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("bus_req", 32'(bus_req), 32'(exp_req));
      chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
      chk("misalign", 32'(misalign), 32'(exp_mis));
      chk("wb_data", wb_data, exp_wb);
      if (exp_fchk) begin
        chk("bus_we", 32'(bus_we), 32'(exp_we));
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_wdata", bus_wdata, exp_wdata);
        chk("bus_be", 32'(bus_be), 32'(exp_be));
      end
      if (stall) tot_stall++;
      if (bus_req) begin
        tot_req++;
        cap_we    = bus_we;
        cap_addr  = bus_addr;
        cap_wdata = bus_wdata;
        cap_be    = bus_be;
      end
      if (wb_valid) begin
        tot_wbv++;
        last_wb = wb_data;
      end
      if (misalign) tot_mis++;
    end
  end

  task automatic idle_inputs();
    wr_en = 0; rsrc = 0; byte_en = 0; alu = 0; rd2 = 0;
    gnt = 0; rvalid = 0; rdata = 0;
  endtask

  // g: REQ cycle (1-based) carrying gnt; r: WAIT cycle carrying rvalid.
  task automatic run_txn(input bit we, input bit ld, input bit b,
                         input logic [31:0] a, input logic [31:0] d,
                         input int g, input int r, input logic [31:0] rd);
    bit load, mis, done;
    int n, s0, q0, w0, m0;
    load = ld && !we;
    mis  = m_trap(b, a);
    n    = mis ? 2 : (load ? g + r + 2 : g + 2);
    s0 = tot_stall; q0 = tot_req; w0 = tot_wbv; m0 = tot_mis;
    exp_we    = we;
    exp_addr  = m_addr(a);
    exp_wdata = m_wdata(b, d);
    exp_be    = m_be(b, a);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      wr_en = we; rsrc = ld; byte_en = b; alu = a; rd2 = d;
      gnt    = !mis && (k == g);
      rvalid = load && !mis && ((k >= 1 && k <= g) || k == g + r);
      rdata  = (k == g + r) ? rd : 32'hA5C3_0F96;
      done      = (k == n - 1);
      exp_stall = !done;
      exp_req   = !mis && k >= 1 && k <= g;
      exp_wbv   = done && load && !mis;
      exp_mis   = done && mis;
      exp_fchk  = exp_req;
      if (exp_wbv) exp_wb = m_load(b, a, rd);
    end
    @(posedge clk); #1;
    idle_inputs();
    exp_stall = 0; exp_req = 0; exp_wbv = 0; exp_mis = 0; exp_fchk = 0;
    @(negedge clk); #1;
    d_stall = tot_stall - s0;
    d_req   = tot_req - q0;
    d_wbv   = tot_wbv - w0;
    d_mis   = tot_mis - m0;
  endtask

  task automatic zero_expect();
    exp_stall = 0; exp_req = 0; exp_wbv = 0; exp_mis = 0;
    exp_fchk = 1; exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
    exp_wb = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst_n = 0;
    idle_inputs();
    wr_en = 1;
    zero_expect();
    chk_en = 1;
    @(posedge clk); #1;
    rst_n = 1;
    wr_en = 0;
    @(posedge clk); #1;
    exp_fchk = 0;

    run_txn(1, 0, 0, 32'h104, 32'hDEAD_BEEF, 3, 1, 0);
    chk("r028_stall_cycles", d_stall, 4);
    chk("r028_be", 32'(cap_be), 32'hF);
    chk("r028_addr", cap_addr, 32'h104);
    chk("r028_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("r028_wbv", d_wbv, 0);

    run_txn(0, 1, 1, 32'h203, 0, 1, 1, 32'h8000_0000);
    chk("r029_be", 32'(cap_be), 32'h8);
    chk("r029_wb", last_wb, 32'hFFFF_FF80);
    chk("r029_wbv", d_wbv, 1);
    chk("r029_stall", d_stall, 3);

    run_txn(1, 0, 1, 32'h11, 32'h0000_00A5, 1, 1, 0);
    chk("r030_be", 32'(cap_be), 32'h2);
    chk("r030_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("r030_wbv", d_wbv, 0);

    run_txn(0, 1, 0, 32'h80, 0, 2, 3, 32'h1357_9BDF);
    chk("wload_wb", last_wb, 32'h1357_9BDF);

    run_txn(0, 1, 1, 32'h41, 0, 1, 2, 32'h1122_7F33);
    chk("bload_pos", last_wb, 32'h0000_007F);

    run_txn(1, 1, 0, 32'h40, 32'hCAFE_F00D, 1, 1, 0);
    chk("r033_we", 32'(cap_we), 1);
    chk("r033_addr", cap_addr, 32'h40);
    chk("r033_wbv", d_wbv, 0);

    run_txn(0, 1, 0, 32'h102, 0, 1, 1, 32'h89AB_CDEF);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("r032_req", d_req, 0);
    chk("r032_mis", d_mis, 1);
    chk("r032_wbv", d_wbv, 0);
`else
    chk("r032_addr", cap_addr, 32'h100);
    chk("r032_wbv", d_wbv, 1);
    chk("r032_wb", last_wb, 32'h89AB_CDEF);
    chk("r032_mis", d_mis, 0);
`endif

    w0 = tot_wbv;
    exp_we = 0; exp_addr = 32'h300; exp_wdata = 0; exp_be = 4'hF;
    @(posedge clk); #1;
    rsrc = 1; alu = 32'h300;
    exp_stall = 1; exp_req = 0; exp_fchk = 0;
    @(posedge clk); #1;
    gnt = 1;
    exp_req = 1; exp_fchk = 1;
    @(posedge clk); #1;
    gnt = 0;
    exp_req = 0; exp_fchk = 0;
    @(posedge clk); #1;
    rst_n = 0;
    zero_expect();
    @(posedge clk); #1;
    rst_n = 1; rsrc = 0; alu = 0;
    gnt = 1; rvalid = 1; rdata = 32'h1234_5678;
    @(posedge clk); #1;
    gnt = 0; rvalid = 0; rdata = 0;
    @(negedge clk); #1;
    chk("r031_wbv", tot_wbv - w0, 0);
    exp_fchk = 0;

    run_txn(1, 0, 1, 32'h2, 32'h1234_56C3, 2, 1, 0);
    chk("post_rst_stall", d_stall, 3);
    chk("post_rst_be", 32'(cap_be), 32'h4);
    chk("post_rst_wdata", cap_wdata, 32'hC3C3_C3C3);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data/address width; only 32 is supported.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_wr_en_m_i  input  1  M-stage store request.
REQ-005 SHALL have port result_src_m_i  input  1  M-stage load request (result from memory).
REQ-006 SHALL have port mem_byte_en_m_i  input  1  1 = byte access, 0 = word access.
REQ-007 SHALL have port alu_result_m_i  input  WIDTH  effective address.
REQ-008 SHALL have port rd_data2_m_i  input  WIDTH  store data.
REQ-009 SHALL have ports bus_req_o, bus_we_o (output 1), bus_addr_o, bus_wdata_o (output WIDTH), bus_be_o (output 4): memory request channel.
REQ-010 SHALL have ports bus_gnt_i, bus_rvalid_i (input 1), bus_rdata_i (input WIDTH): grant and read-response channel.
REQ-011 SHALL have ports stall_o (output 1, holds IF/ID/E/M stages), wb_data_o (output WIDTH), wb_valid_o (output 1), misalign_o (output 1).

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-013 IDLE: access present (load or store) -> REQ next cycle; otherwise stay; stall_o SHALL be asserted combinationally in IDLE while an access is present.
REQ-014 If mem_wr_en_m_i and result_src_m_i are both high, SHALL treat the access as a store, with no write-back.
REQ-015 REQ: bus_req_o high, bus request fields registered on IDLE->REQ and held constant until bus_gnt_i is sampled high.
REQ-016 REQ with bus_gnt_i high: store -> DONE; load -> WAIT; bus_req_o SHALL drop on the following cycle.
REQ-017 WAIT: on bus_rvalid_i high, SHALL capture the formatted read data into wb_data_o and go to DONE; bus_rvalid_i outside WAIT SHALL be ignored.
REQ-018 stall_o SHALL be high in REQ and WAIT and low in DONE; DONE SHALL always go to IDLE after one cycle.
REQ-019 wb_valid_o SHALL be a single-cycle pulse in DONE for loads only; wb_data_o SHALL hold its value until the next load capture.
REQ-020 Word access: bus_be_o = 4'hF, bus_addr_o = {addr[31:2],2'b00}, bus_wdata_o = rd_data2_m_i.
REQ-021 Byte access: bus_be_o = 4'b0001 << addr[1:0], bus_addr_o = word-aligned address, bus_wdata_o = rd_data2_m_i[7:0] replicated into all four lanes.
REQ-022 Byte load: SHALL select lane addr[1:0] of bus_rdata_i and sign-extend it to WIDTH.
REQ-023 Minimum latency: store 3 cycles (IDLE, REQ, DONE) with gnt in the first REQ cycle; load 4 cycles with rvalid in the first WAIT cycle.

Reset
REQ-024 rst_n_i low SHALL immediately force IDLE, with bus_req_o, bus_we_o, stall_o, wb_valid_o, misalign_o = 0, bus_addr_o, bus_wdata_o, wb_data_o = 0, and bus_be_o = 0.
REQ-025 Reset mid-transaction SHALL abandon the pending access; a late gnt or rvalid after reset release SHALL be ignored.

Configuration
REQ-026 Macro LSU_MISALIGN_TRAP_EN defined: a word access with addr[1:0] != 0 SHALL issue no bus request, go IDLE->DONE, pulse misalign_o in DONE, and suppress wb_valid_o.
REQ-027 Macro LSU_MISALIGN_TRAP_EN undefined: addr[1:0] SHALL be ignored for word accesses, the access proceeds aligned, and misalign_o SHALL be tied 0.

Verification
REQ-028 Word store addr 0x104, data 0xDEADBEEF, gnt after 2 REQ cycles -> bus_be_o = F, bus_addr_o = 0x104, stall high for 4 cycles, no wb_valid_o.
REQ-029 Byte load addr 0x203, rdata 0x80000000 -> bus_be_o = 4'b1000, wb_data_o = 0xFFFFFF80, wb_valid_o pulses once.
REQ-030 Byte store addr 0x11, rd_data2 = 0x000000A5 -> bus_be_o = 4'b0010, bus_wdata_o = 0xA5A5A5A5.
REQ-031 Load issued, rst_n_i asserted in WAIT, then a stray rvalid after release -> outputs zero, FSM in IDLE, no wb_valid_o.
REQ-032 Word load addr 0x102 -> with LSU_MISALIGN_TRAP_EN: no bus_req_o, misalign_o pulses; without: bus_addr_o = 0x100 and the load completes.
REQ-033 Store and load asserted together at addr 0x40 -> bus_we_o = 1, no wb_valid_o.
